// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters with horizontal and vertical phase FSMs
// producing registered sync, blanking and line/frame start pulses on pix_en ticks.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter bit          SYNC_ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_cfg_error
      $error("vga_sync_gen: H_TOTAL (%0d) and V_TOTAL (%0d) must not exceed 1024",
             H_TOTAL, V_TOTAL);
    end
  endgenerate

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Level driven on hsync/vsync outside the sync pulse.
  localparam logic SYNC_IDLE = SYNC_ACT_LOW;

  typedef enum logic [1:0] {
    PH_ACT,
    PH_FP,
    PH_SYNC,
    PH_BP
  } phase_t;

  phase_t     h_state, h_state_nxt;
  phase_t     v_state, v_state_nxt;
  logic [9:0] x_nxt, y_nxt;
  logic       h_wrap, v_wrap;
  logic       hsync_nxt, vsync_nxt, video_on_nxt;

  // Counter arithmetic; y only moves on the horizontal wrap.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    x_nxt  = x;
    y_nxt  = y;
    h_wrap = pix_en && (x == H_LAST);
    v_wrap = h_wrap && (y == V_LAST);
    if (pix_en) begin
      x_nxt = h_wrap ? 10'd0 : x + 10'd1;
    end
    if (h_wrap) begin
      y_nxt = v_wrap ? 10'd0 : y + 10'd1;
    end
  end

  // Phase FSMs look at the counter value being loaded, so the registered phase
  // always describes the registered (x,y) with no extra cycle of lag.
  always_comb begin
    h_state_nxt = h_state;
    if (pix_en) begin
      case (h_state)
        PH_ACT:  if (x_nxt == H_FP_START)   h_state_nxt = PH_FP;
        PH_FP:   if (x_nxt == H_SYNC_START) h_state_nxt = PH_SYNC;
        PH_SYNC: if (x_nxt == H_BP_START)   h_state_nxt = PH_BP;
        PH_BP:   if (h_wrap)                h_state_nxt = PH_ACT;
        default:                            h_state_nxt = PH_BP;
      endcase
    end
  end

  always_comb begin
    v_state_nxt = v_state;
    if (h_wrap) begin
      case (v_state)
        PH_ACT:  if (y_nxt == V_FP_START)   v_state_nxt = PH_FP;
        PH_FP:   if (y_nxt == V_SYNC_START) v_state_nxt = PH_SYNC;
        PH_SYNC: if (y_nxt == V_BP_START)   v_state_nxt = PH_BP;
        PH_BP:   if (v_wrap)                v_state_nxt = PH_ACT;
        default:                            v_state_nxt = PH_BP;
      endcase
    end
  end

  always_comb begin
    hsync_nxt    = (h_state_nxt == PH_SYNC) ? ~SYNC_IDLE : SYNC_IDLE;
    vsync_nxt    = (v_state_nxt == PH_SYNC) ? ~SYNC_IDLE : SYNC_IDLE;
    video_on_nxt = (h_state_nxt == PH_ACT) && (v_state_nxt == PH_ACT);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the pre-edge values regardless of statement order.
    if (rst) begin
      h_state <= PH_BP;
      v_state <= PH_BP;
    end else begin
      h_state <= h_state_nxt;
      v_state <= v_state_nxt;
    end
  end

  // Pulses are rewritten every clk (0 on idle clocks); everything else holds
  // unless pix_en is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x           <= H_LAST;
      y           <= V_LAST;
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      if (pix_en) begin
        x        <= x_nxt;
        y        <= y_nxt;
        hsync    <= hsync_nxt;
        vsync    <= vsync_nxt;
        video_on <= video_on_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen on a reduced raster: arithmetic reference
// model over the linear pixel position, directed phases plus random pix_en/reset.
module tb_vga_sync_gen;

  localparam int HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_en = 1'b0;
  logic       hsync_lo, vsync_lo, video_on_lo, line_start_lo, frame_start_lo;
  logic       hsync_hi, vsync_hi, video_on_hi, line_start_hi, frame_start_hi;
  logic [9:0] x_lo, y_lo, x_hi, y_hi;

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACT_LOW(1'b1)
  ) dut_lo (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(hsync_lo), .vsync(vsync_lo), .video_on(video_on_lo),
    .x(x_lo), .y(y_lo), .line_start(line_start_lo), .frame_start(frame_start_lo)
  );

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACT_LOW(1'b0)
  ) dut_hi (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(hsync_hi), .vsync(vsync_hi), .video_on(video_on_hi),
    .x(x_hi), .y(y_hi), .line_start(line_start_hi), .frame_start(frame_start_hi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: current pixel position and expected pulses.
  int mx, my;
  bit exp_ls, exp_fs;

  // Period / width measurement; mult = clocks per pixel tick, 0 disables.
  int cyc = 0;
  int mult = 0;
  int last_ls = -1, last_fs = -1;
  int hs_cnt = 0, vs_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_hsync(int px);
    return (px >= HA + HF) && (px < HA + HF + HS);
  endfunction

  function automatic bit in_vsync(int py);
    return (py >= VA + VF) && (py < VA + VF + VS);
  endfunction

  task automatic model_reset();
    mx     = HT - 1;
    my     = VT - 1;
    exp_ls = 1'b0;
    exp_fs = 1'b0;
  endtask

  task automatic check_outputs();
    bit vid;
    vid = (mx < HA) && (my < VA);
    check("x_lo",        x_lo,           mx);
    check("y_lo",        y_lo,           my);
    check("video_on_lo", video_on_lo,    vid);
    check("hsync_lo",    hsync_lo,       !in_hsync(mx));
    check("vsync_lo",    vsync_lo,       !in_vsync(my));
    check("line_lo",     line_start_lo,  exp_ls);
    check("frame_lo",    frame_start_lo, exp_fs);
    check("x_hi",        x_hi,           mx);
    check("y_hi",        y_hi,           my);
    check("video_on_hi", video_on_hi,    vid);
    check("hsync_hi",    hsync_hi,       in_hsync(mx));
    check("vsync_hi",    vsync_hi,       in_vsync(my));
    check("line_hi",     line_start_hi,  exp_ls);
    check("frame_hi",    frame_start_hi, exp_fs);
  endtask

  task automatic start_measure(input int m);
    mult    = m;
    last_ls = -1;
    last_fs = -1;
    hs_cnt  = 0;
    vs_cnt  = 0;
  endtask

  // One clk with the given pix_en; inputs change and outputs are sampled 1 time
  // unit after the rising edge.
  task automatic tick(input bit en);
    int pos;
    pix_en = en;
    @(posedge clk);
    cyc++;
    if (en) begin
      pos    = (my * HT + mx + 1) % (HT * VT);
      mx     = pos % HT;
      my     = pos / HT;
      exp_ls = (mx == 0);
      exp_fs = (pos == 0);
    end else begin
      exp_ls = 1'b0;
      exp_fs = 1'b0;
    end
    #1;
    check_outputs();
    if (mult != 0) begin
      if (line_start_lo) begin
        if (last_ls >= 0) begin
          check("line_period", cyc - last_ls, mult * HT);
          check("hsync_width", hs_cnt, mult * HS);
        end
        last_ls = cyc;
        hs_cnt  = 0;
      end
      if (frame_start_lo) begin
        if (last_fs >= 0) begin
          check("frame_period", cyc - last_fs, mult * HT * VT);
          check("vsync_width", vs_cnt, mult * HT * VS);
        end
        last_fs = cyc;
        vs_cnt  = 0;
      end
      if (!hsync_lo) hs_cnt++;
      if (!vsync_lo) vs_cnt++;
    end
  endtask

  task automatic goto_pos(input int tx, input int ty);
    for (int i = 0; i < HT * VT + 1; i++) begin
      if (mx == tx && my == ty) break;
      tick(1'b1);
    end
    check("goto_x", x_lo, tx);
    check("goto_y", y_lo, ty);
  endtask

  initial begin
    model_reset();

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #2 check_outputs();
    repeat (3) @(posedge clk);
    #1 check_outputs();

    // Release with pix_en high: first edge wraps to (0,0) with both pulses.
    rst = 1'b0;
    tick(1'b1);
    check("first_frame_start", frame_start_lo, 1'b1);
    check("first_line_start",  line_start_lo,  1'b1);

    // Continuous pix_en: two full frames with line/frame period and sync widths.
    start_measure(1);
    repeat (2 * HT * VT) tick(1'b1);

    // pix_en toggling every other clk doubles every period.
    start_measure(2);
    repeat (2 * HT * VT + 1) begin
      tick(1'b1);
      tick(1'b0);
    end
    start_measure(0);

    // Random pix_en density.
    repeat (2000) tick($urandom_range(0, 3) != 0);

    // Freeze with pix_en low for 100 clk, then resume one pixel later.
    goto_pos(HA / 2, 2);
    repeat (100) tick(1'b0);
    tick(1'b1);
    check("resume_x", x_lo, HA / 2 + 1);

    // Asynchronous reset mid-sync (both hsync and vsync active), between edges.
    goto_pos(HA + HF + 1, VA + VF + 1);
    #3 rst = 1'b1;
    model_reset();
    #1 check_outputs();
    @(posedge clk);
    #1 check_outputs();
    rst = 1'b0;
    tick(1'b1);
    check("post_reset_frame", frame_start_lo, 1'b1);

    // Random mid-frame reset pulses.
    repeat (4) begin
      repeat ($urandom_range(50, 600)) tick($urandom_range(0, 1) != 0);
      #2 rst = 1'b1;
      model_reset();
      #1 check_outputs();
      #2 rst = 1'b0;
    end
    repeat (HT * VT + 5) tick($urandom_range(0, 1) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
